// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and length helpers for the systolic MAC
// array, its operand buffers and the sequencer that drives them.
package systolic_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int N          = 3;
  localparam int M          = 3;
  localparam int K_MAX      = 16;
  localparam int MAC_LAT    = 1;
  localparam int KW         = $clog2(K_MAX + 1);

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CLEAR = 3'd1,
    SEQ_FEED  = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_LOAD  = 3'd4,
    SEQ_DONE  = 3'd5
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // The last lane starts max(N,M)-1 cycles late and then streams k operands.
  function automatic int feed_len(input int k, input int n, input int m);
    return k + max2(n, m) - 1;
  endfunction

  // Wavefront still travelling to the far corner PE, plus MAC latency.
  function automatic int drain_len(input int n, input int m, input int lat);
    return min2(n, m) - 1 + lat;
  endfunction

  function automatic int cnt_width(input int kmax, input int n, input int m, input int lat);
    return $clog2(kmax + max2(n, m) + lat + 1);
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One operand-read lane: enables the buffer for k cycles starting OFFSET
// cycles into FEED and presents the k index being read.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int OFFSET = 0,
  parameter int KW     = systolic_pkg::KW,
  parameter int CW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic [KW-1:0] k,
  input  logic          feed,
  output logic          rd_en,
  output logic [KW-1:0] rd_k
);

  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LO = CW1'(OFFSET);

  logic [CW:0] pos;
  logic [CW:0] hi;
  logic        hit;

  // One extra bit keeps OFFSET+k from wrapping.
  always_comb begin
    pos = {1'b0, cnt};
    hi  = LO + CW1'(k);
    hit = feed && (pos >= LO) && (pos < hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en <= 1'b0;
      rd_k  <= '0;
    end else begin
      rd_en <= hit;
      rd_k  <= hit ? KW'(cnt - CW'(OFFSET)) : '0;
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Tile sequencer for the output-stationary MAC array: clear, skewed operand
// feed, drain, then C capture via load and a done pulse.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int N          = systolic_pkg::N,
  parameter int M          = systolic_pkg::M,
  parameter int K_MAX      = systolic_pkg::K_MAX,
  parameter int MAC_LAT    = systolic_pkg::MAC_LAT,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            aborted,
  output logic            mac_clear,
  output logic            load,
  output logic [N-1:0]    a_rd_en,
  output logic [N*KW-1:0] a_rd_k,
  output logic [M-1:0]    b_rd_en,
  output logic [M*KW-1:0] b_rd_k
);

  localparam int CW = cnt_width(K_MAX, N, M, MAC_LAT);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N, M, MAC_LAT) - 1);

  if (DATA_WIDTH < 1 || K_MAX < 1 || MAC_LAT < 1) begin : g_param_check
    $error("systolic_sequencer: DATA_WIDTH, K_MAX and MAC_LAT must be >= 1");
  end

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, feed_last;
  logic [KW-1:0] k_q;
  logic          k_ok, accept, reject, abort_take, feed_nxt;

  always_comb begin
    k_ok       = (k_len != '0) && (k_len <= KW'(K_MAX));
    feed_last  = CW'(feed_len(int'(k_q), N, M) - 1);
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    reject     = 1'b0;
    abort_take = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          if (k_ok) begin
            accept    = 1'b1;
            state_nxt = SEQ_CLEAR;
          end else begin
            reject = 1'b1;
          end
        end
      end
      SEQ_CLEAR: begin
        if (abort) begin
          abort_take = 1'b1;
          state_nxt  = SEQ_IDLE;
        end else begin
          state_nxt = SEQ_FEED;
          cnt_nxt   = '0;
        end
      end
      SEQ_FEED: begin
        if (abort) begin
          abort_take = 1'b1;
          state_nxt  = SEQ_IDLE;
        end else if (cnt == feed_last) begin
          state_nxt = SEQ_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SEQ_DRAIN: begin
        if (abort) begin
          abort_take = 1'b1;
          state_nxt  = SEQ_IDLE;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = SEQ_LOAD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SEQ_LOAD: state_nxt = SEQ_DONE;
      SEQ_DONE: state_nxt = SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
    feed_nxt = (state_nxt == SEQ_FEED);
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
      mac_clear <= 1'b0;
      load      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt != SEQ_IDLE);
      done      <= (state_nxt == SEQ_DONE);
      err       <= reject;
      aborted   <= abort_take;
      mac_clear <= (state_nxt == SEQ_CLEAR);
      load      <= (state_nxt == SEQ_LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) k_q <= k_len;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    systolic_skew_lane #(.OFFSET(i), .KW(KW), .CW(CW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt_nxt),
      .k     (k_q),
      .feed  (feed_nxt),
      .rd_en (a_rd_en[i]),
      .rd_k  (a_rd_k[i*KW +: KW])
    );
  end

  for (genvar j = 0; j < M; j++) begin : g_col
    systolic_skew_lane #(.OFFSET(j), .KW(KW), .CW(CW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .cnt   (cnt_nxt),
      .k     (k_q),
      .feed  (feed_nxt),
      .rd_en (b_rd_en[j]),
      .rd_k  (b_rd_k[j*KW +: KW])
    );
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomised and directed bench for systolic_sequencer against a
// cycle-offset reference model of the tile timeline.
module tb_systolic_sequencer;

  localparam int N       = 3;
  localparam int M       = 3;
  localparam int K_MAX   = 16;
  localparam int MAC_LAT = 1;
  localparam int KW      = $clog2(K_MAX + 1);
  localparam int MX      = (N > M) ? N : M;
  localparam int MN      = (N < M) ? N : M;

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [KW-1:0]   k_len;
  logic            busy, done, err, aborted, mac_clear, load;
  logic [N-1:0]    a_rd_en;
  logic [N*KW-1:0] a_rd_k;
  logic [M-1:0]    b_rd_en;
  logic [M*KW-1:0] b_rd_k;

  systolic_sequencer #(
    .DATA_WIDTH(32), .N(N), .M(M), .K_MAX(K_MAX), .MAC_LAT(MAC_LAT), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .aborted(aborted),
    .mac_clear(mac_clear), .load(load),
    .a_rd_en(a_rd_en), .a_rd_k(a_rd_k), .b_rd_en(b_rd_en), .b_rd_k(b_rd_k)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_done_cyc = -1;

  // Reference model: tile anchored at the accepting edge, outputs derived
  // from the cycle offset d since that edge.
  bit act    = 1'b0;
  int base   = 0;
  int kk     = 0;
  bit err_p  = 1'b0;
  bit ab_p   = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic expect_now();
    logic            e_busy, e_clr, e_load, e_done;
    logic [N-1:0]    e_ae;
    logic [N*KW-1:0] e_ak;
    logic [M-1:0]    e_be;
    logic [M*KW-1:0] e_bk;
    int d, f, tot, c;
    e_busy = 0; e_clr = 0; e_load = 0; e_done = 0;
    e_ae = '0; e_ak = '0; e_be = '0; e_bk = '0;
    if (act) begin
      d   = cyc - base;
      f   = kk + MX - 1;
      tot = kk + N + M + MAC_LAT + 1;
      e_busy = 1;
      e_clr  = (d == 1);
      e_load = (d == tot - 1);
      e_done = (d == tot);
      if (d >= 2 && d <= f + 1) begin
        c = d - 2;
        for (int i = 0; i < N; i++)
          if (c >= i && c < i + kk) begin
            e_ae[i] = 1'b1;
            e_ak[i*KW +: KW] = KW'(c - i);
          end
        for (int j = 0; j < M; j++)
          if (c >= j && c < j + kk) begin
            e_be[j] = 1'b1;
            e_bk[j*KW +: KW] = KW'(c - j);
          end
      end
    end
    if (done) last_done_cyc = cyc;
    check_val("ctrl", 64'({busy, mac_clear, load, done, err, aborted}),
              64'({e_busy, e_clr, e_load, e_done, err_p, ab_p}));
    check_val("a_en", 64'(a_rd_en), 64'(e_ae));
    check_val("a_k",  64'(a_rd_k),  64'(e_ak));
    check_val("b_en", 64'(b_rd_en), 64'(e_be));
    check_val("b_k",  64'(b_rd_k),  64'(e_bk));
  endtask

  task automatic step(input bit st, input int kl, input bit ab, input bit r);
    int d, f, dr, tot;
    bit n_err, n_ab;
    start = st; k_len = KW'(kl); abort = ab; rst = r;
    n_err = 0; n_ab = 0;
    if (r) begin
      act = 0;
    end else if (!act) begin
      if (st) begin
        if (kl >= 1 && kl <= K_MAX) begin
          act = 1; base = cyc; kk = kl;
        end else begin
          n_err = 1;
        end
      end
    end else begin
      d   = cyc - base;
      f   = kk + MX - 1;
      dr  = MN - 1 + MAC_LAT;
      tot = kk + N + M + MAC_LAT + 1;
      if (ab && d >= 1 && d <= f + dr + 1) begin
        act = 0; n_ab = 1;
      end else if (d == tot) begin
        act = 0;
      end
    end
    err_p = n_err; ab_p = n_ab;
    @(posedge clk);
    #1;
    cyc++;
    expect_now();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    idle(2);

    s0 = cyc; step(1, 4, 0, 0); idle(14);
    check_val("k4_done_cycle", 64'(last_done_cyc - s0), 64'd12);

    s0 = cyc; step(1, 1, 0, 0); idle(10);
    check_val("k1_done_cycle", 64'(last_done_cyc - s0), 64'd9);

    step(1, 0, 0, 0); idle(2);
    step(1, 17, 0, 0); idle(2);

    for (int i = 0; i < 22; i++) step(1, 2, 0, 0);
    idle(3);

    step(1, 8, 0, 0); idle(3); step(0, 0, 1, 0); idle(4);
    step(1, 5, 1, 0); step(0, 0, 1, 0); idle(2);

    step(1, 4, 0, 0); idle(8); step(0, 0, 0, 1); idle(2);
    s0 = cyc; step(1, 4, 0, 0); idle(14);
    check_val("rst_k4_done_cycle", 64'(last_done_cyc - s0), 64'd12);

    s0 = cyc; step(1, 16, 0, 0); idle(26);
    check_val("k16_done_cycle", 64'(last_done_cyc - s0), 64'd24);

    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) == 0, int'($urandom_range(0, 18)),
           ($urandom % 40) == 0, ($urandom % 150) == 0);
    idle(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Control FSM for the N×M output-stationary MAC array. On a `start` handshake it clears the accumulators and generates skewed per-row and per-column operand-read strobes with k-indices, so the operand buffers feed A rows and B columns in systolic wavefront order. It then waits for the pipeline to drain and pulses `load` to capture the C results, followed by a `done` pulse. It replaces the free-running test controller as the owner of the array's `load` signal.

## Interface
- `DATA_WIDTH`, default 32: operand width; pass-through only, used by package consumers.
- `N`, default 3: array rows (A streams).
- `M`, default 3: array columns (B streams).
- `K_MAX`, default 16: maximum inner dimension.
- `MAC_LAT`, default 1: MAC accumulate latency in cycles.
- `KW`, default $clog2(K_MAX+1): width of k values.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a tile; sampled only in IDLE.
- `k_len`  in  KW  inner dimension; latched when `start` is accepted.
- `abort`  in  1  cancel the current tile.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tile completes.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `aborted`  out  1  one-cycle pulse when an abort is taken.
- `mac_clear`  out  1  clears all accumulators.
- `load`  out  1  C-capture strobe to the array.
- `a_rd_en`  out  N  per-row A read enable.
- `a_rd_k`  out  N*KW  per-row k index; row i is at [i*KW +: KW].
- `b_rd_en`  out  M  per-column B read enable.
- `b_rd_k`  out  M*KW  per-column k index; column j is at [j*KW +: KW].

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, LOAD, DONE.
- IDLE:
  - `start` with 1 ≤ `k_len` ≤ K_MAX: latch `k_len`, go to CLEAR.
  - `start` with `k_len` = 0 or `k_len` > K_MAX: pulse `err`, stay in IDLE.
- CLEAR: `mac_clear`=1 for one cycle; clear `cnt` to 0; go to FEED.
- FEED: lasts k+max(N,M)−1 cycles, with `cnt` counting from 0.
  - Row i: `a_rd_en[i]`=1 when i ≤ cnt < i+k, and `a_rd_k[i]` = cnt−i.
  - Column j: same rule with j.
  - When an enable is low, its index is 0. The buffer drives zero into the array when its enable is low.
- DRAIN: lasts min(N,M)−1+MAC_LAT cycles. All read enables are low.
- LOAD: `load`=1 for one cycle.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- `abort`:
  - Takes effect in CLEAR, FEED or DRAIN: go to IDLE next cycle, pulse `aborted`, no `load`, no `done`. Accumulators are left dirty.
  - Ignored in IDLE, LOAD and DONE.
- Counter width is $clog2(K_MAX+max(N,M)+MAC_LAT+1). Comparisons are unsigned, with no wrap within the legal range.

## Timing
- All outputs are registered.
- Reset value is 0 for every output; the state resets to IDLE.
- `rst` mid-tile:
  - Returns to IDLE at the next edge.
  - Every strobe is low in the following cycle.
  - No `done`, `err` or `aborted` pulse is produced.
- `start` is accepted at edge t:
  - CLEAR is the cycle after edge t.
  - FEED is the first cycle after CLEAR.
- Operand buffers have a 1-cycle read latency: data enters the array the cycle after the enable.
- The last product reaches PE(N−1,M−1) and is accumulated k+N+M−2+MAC_LAT cycles after FEED starts; this equals FEED+DRAIN length.
- `load` is in the cycle after the last DRAIN cycle; `done` follows one cycle later.
- Total `busy` time is k+N+M+MAC_LAT+1 cycles.
- `abort` and `rst` together: `rst` wins.

## Structure
- Package `systolic_pkg`:
  - Holds N, M, DATA_WIDTH, K_MAX, MAC_LAT and KW, shared with the MAC array and the operand buffers.
  - Holds the `seq_state_t` enum.
  - Holds the FEED/DRAIN length constant functions.
- Sub-module `systolic_skew_lane`:
  - One instance per row and one per column, parameterised by lane offset.
  - Takes `cnt`, `k` and the FEED flag; produces `rd_en` and `rd_k`.
  - The top level holds the FSM, counter and latched k.

## Test plan
All scenarios use N=M=3, MAC_LAT=1, K_MAX=16; `start` is sampled at edge 0.
- **k_len=4:**
  - CLEAR in cycle 1, FEED in cycles 2–7, DRAIN in cycles 8–10.
  - `load` in cycle 11, `done` in cycle 12, `busy` high for cycles 1–12.
  - `a_rd_en[2]` high in cycles 4–7 with `a_rd_k` 0,1,2,3.
- **k_len=1:**
  - FEED is 3 cycles; `a_rd_en[i]` and `b_rd_en[i]` each pulse once, at FEED cycle i, with k=0.
  - `done` in cycle 9.
- **k_len=0, then k_len=17:** `err` pulses one cycle after each; `busy` stays 0; no `mac_clear`.
- **`start` held high through a k_len=2 tile:** no restart until IDLE; a second tile begins the cycle after `done` drops.
- **`abort` in FEED cycle 3 (k_len=8):** `aborted` pulses; IDLE the next cycle; `load` and `done` never assert; all enables drop.
- **`rst` asserted in DRAIN:** all outputs are 0 after the edge; a subsequent `start` with k_len=4 reproduces scenario 1 timing exactly.
